ts_packet_tx: RTL and testbench

TS_PACKET_TX -- requirements
Module: ts_packet_tx

---
 rtl/ts_packet_tx.sv | 147 ++++++++++++++
 tb/tb_ts_packet_tx.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ts_packet_tx.sv
// Transport-stream packet replayer: reads stored packets from byte memory and
// emits them as a byte stream with a fixed idle gap between packets.
module ts_packet_tx #(
   parameter int PKT_LEN = 188,
   parameter int GAP_LEN = 4,
   parameter int AW      = 20,
   parameter int NW      = 16
) (
   input  logic          CLOCK,
   input  logic          RESET,
   input  logic          START,
   input  logic          STOP,
   input  logic          LOOP,
   input  logic [NW-1:0] NUM_PKTS,
   output logic          MEM_RD,
   output logic [AW-1:0] MEM_ADDR,
   input  logic [7:0]    MEM_DATA,
   output logic          TS_VALID,
   output logic          TS_SYNC,
   output logic [7:0]    TS_DATA,
   output logic          BUSY,
   output logic          DONE,
   output logic          SYNC_ERR
);

   localparam int BW = $clog2(PKT_LEN + 1);
   localparam int GW = $clog2(GAP_LEN + 1);

   typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

   state_t        state;
   logic [BW-1:0] bcnt;
   logic [GW-1:0] gcnt;
   logic [NW-1:0] pcnt;
   logic [NW-1:0] num_l;
   logic          stop_l;
   logic          fin;
   logic          rd_d1;
   logic          sync_d1;

   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         state    <= IDLE;
         bcnt     <= '0;
         gcnt     <= '0;
         pcnt     <= '0;
         num_l    <= '0;
         stop_l   <= 1'b0;
         fin      <= 1'b0;
         rd_d1    <= 1'b0;
         sync_d1  <= 1'b0;
         MEM_RD   <= 1'b0;
         MEM_ADDR <= '0;
         TS_VALID <= 1'b0;
         TS_SYNC  <= 1'b0;
         TS_DATA  <= 8'h00;
         BUSY     <= 1'b0;
         DONE     <= 1'b0;
         SYNC_ERR <= 1'b0;
      end else begin
         DONE <= 1'b0;

         // Output pipeline: MEM_DATA lands one cycle after the read, then is registered.
         rd_d1    <= MEM_RD;
         sync_d1  <= MEM_RD && (bcnt == '0);
         TS_VALID <= rd_d1;
         TS_SYNC  <= rd_d1 && sync_d1;
         TS_DATA  <= rd_d1 ? MEM_DATA : 8'h00;

         if (TS_SYNC && (TS_DATA != 8'h47))
            SYNC_ERR <= 1'b1;
         if (BUSY && STOP)
            stop_l <= 1'b1;

         case (state)
            IDLE: begin
               if (START && !STOP) begin
                  SYNC_ERR <= 1'b0;
                  if (NUM_PKTS == '0) begin
                     DONE <= 1'b1;
                  end else begin
                     state    <= SEND;
                     MEM_RD   <= 1'b1;
                     MEM_ADDR <= '0;
                     num_l    <= NUM_PKTS;
                     pcnt     <= '0;
                     bcnt     <= '0;
                     BUSY     <= 1'b1;
                     stop_l   <= 1'b0;
                     fin      <= 1'b0;
                  end
               end
            end

            SEND: begin
               MEM_ADDR <= MEM_ADDR + AW'(1);
               bcnt     <= bcnt + BW'(1);
               if (bcnt == BW'(PKT_LEN - 1)) begin
                  // Last read of this packet decides what follows the gap.
                  MEM_RD <= 1'b0;
                  state  <= GAP;
                  gcnt   <= '0;
                  bcnt   <= '0;
                  if (stop_l || STOP) begin
                     fin <= 1'b1;
                  end else if (pcnt == num_l - NW'(1)) begin
                     if (LOOP) begin
                        MEM_ADDR <= '0;
                        pcnt     <= '0;
                     end else begin
                        fin <= 1'b1;
                     end
                  end else begin
                     pcnt <= pcnt + NW'(1);
                  end
               end
            end

            GAP: begin
               if (fin) begin
                  // Last byte leaves the pipeline on this edge.
                  DONE   <= 1'b1;
                  BUSY   <= 1'b0;
                  fin    <= 1'b0;
                  stop_l <= 1'b0;
                  state  <= IDLE;
               end else if (gcnt == GW'(GAP_LEN - 1)) begin
                  if (stop_l || STOP) begin
                     DONE   <= 1'b1;
                     BUSY   <= 1'b0;
                     stop_l <= 1'b0;
                     state  <= IDLE;
                  end else begin
                     MEM_RD <= 1'b1;
                     state  <= SEND;
                  end
               end else begin
                  gcnt <= gcnt + GW'(1);
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ts_packet_tx.sv
// Directed bench for ts_packet_tx: scenario table plus hand-written timing sequences.
module tb_ts_packet_tx;

   localparam int PKT_LEN = 188;
   localparam int GAP_LEN = 4;
   localparam int AW      = 20;
   localparam int NW      = 16;

   logic          CLOCK = 1'b0;
   logic          RESET = 1'b1;
   logic          START = 1'b0;
   logic          STOP  = 1'b0;
   logic          LOOP  = 1'b0;
   logic [NW-1:0] NUM_PKTS = '0;
   logic          MEM_RD;
   logic [AW-1:0] MEM_ADDR;
   logic [7:0]    MEM_DATA = 8'h00;
   logic          TS_VALID, TS_SYNC, BUSY, DONE, SYNC_ERR;
   logic [7:0]    TS_DATA;

   ts_packet_tx #(.PKT_LEN(PKT_LEN), .GAP_LEN(GAP_LEN), .AW(AW), .NW(NW)) dut (
      .CLOCK(CLOCK), .RESET(RESET), .START(START), .STOP(STOP), .LOOP(LOOP),
      .NUM_PKTS(NUM_PKTS), .MEM_RD(MEM_RD), .MEM_ADDR(MEM_ADDR), .MEM_DATA(MEM_DATA),
      .TS_VALID(TS_VALID), .TS_SYNC(TS_SYNC), .TS_DATA(TS_DATA), .BUSY(BUSY),
      .DONE(DONE), .SYNC_ERR(SYNC_ERR)
   );

   always #5 CLOCK = ~CLOCK;

   logic [7:0] mem [0:511];

   always @(posedge CLOCK)
      if (MEM_RD) MEM_DATA <= mem[MEM_ADDR[8:0]];

   int checks = 0;
   int errors = 0;

   // Monitor state
   bit mon_en = 1'b0;
   int valid_cnt, rd_cnt, done_cnt, busy_cnt, rd0_cnt, last_addr, mon_bad;
   int vrun, irun;
   bit prev_v, seen;
   int addr_q[$];

   task automatic reset_mon();
      valid_cnt = 0; rd_cnt = 0; done_cnt = 0; busy_cnt = 0; rd0_cnt = 0;
      last_addr = -1; mon_bad = 0; vrun = 0; irun = 0; prev_v = 1'b0; seen = 1'b0;
      addr_q.delete();
   endtask

   always @(negedge CLOCK) begin
      if (mon_en && !RESET) begin
         if (MEM_RD) begin
            rd_cnt++;
            last_addr = int'(MEM_ADDR);
            if (MEM_ADDR == '0) rd0_cnt++;
            addr_q.push_back(int'(MEM_ADDR));
         end
         if (DONE) done_cnt++;
         if (BUSY) busy_cnt++;
         if (TS_VALID) begin
            valid_cnt++;
            if (addr_q.size() == 0) mon_bad++;
            else begin
               int a;
               a = addr_q.pop_front();
               if (TS_DATA != mem[a[8:0]] || TS_SYNC != ((a % PKT_LEN) == 0)) mon_bad++;
            end
            if (!prev_v && seen && irun != GAP_LEN) mon_bad++;
            vrun = prev_v ? vrun + 1 : 1;
         end else begin
            if (TS_SYNC || TS_DATA != 8'h00) mon_bad++;
            if (prev_v) begin
               if (vrun != PKT_LEN) mon_bad++;
               seen = 1'b1;
            end
            irun = prev_v ? 1 : irun + 1;
         end
         prev_v = TS_VALID;
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLOCK);
      #1;
   endtask

   task automatic pulse_start(input int n);
      START = 1'b1;
      NUM_PKTS = NW'(n);
      tick();
      START = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int c;
      c = 0;
      while (!DONE && c < 3000) begin
         tick();
         c++;
      end
      chk({name, "_timeout"}, int'(DONE), 1);
   endtask

   typedef struct {
      string name;
      int    num;
      bit    loop;
      int    stop_at;
      bit    bad0;
      int    exp_valid;
      int    exp_rd;
      int    exp_rd0;
      int    exp_last;
      bit    exp_serr;
   } vec_t;

   vec_t vecs [7];

   initial begin
      for (int i = 0; i < 512; i++)
         mem[i] = ((i % PKT_LEN) == 0) ? 8'h47 : 8'((i % PKT_LEN));

      vecs[0] = '{"two_pkts",   2, 1'b0, -1,  1'b0, 376, 376, 1, 375, 1'b0};
      vecs[1] = '{"zero_pkts",  0, 1'b0, -1,  1'b0,   0,   0, 0,  -1, 1'b0};
      vecs[2] = '{"one_pkt",    1, 1'b0, -1,  1'b0, 188, 188, 1, 187, 1'b0};
      vecs[3] = '{"stop_mid",   3, 1'b0, 238, 1'b0, 376, 376, 1, 375, 1'b0};
      vecs[4] = '{"stop_gap",   3, 1'b0, 188, 1'b0, 188, 188, 1, 187, 1'b0};
      vecs[5] = '{"loop3",      1, 1'b1, 386, 1'b0, 564, 564, 3, 187, 1'b0};
      vecs[6] = '{"sync_err",   2, 1'b0, -1,  1'b1, 376, 376, 1, 375, 1'b1};

      // Reset state, checked while reset is held
      #2;
      chk("reset_outs_zero", int'({MEM_RD, MEM_ADDR, TS_VALID, TS_SYNC, TS_DATA,
                                   BUSY, DONE, SYNC_ERR} == '0), 1);
      tick(); tick();
      RESET = 1'b0;
      tick();

      foreach (vecs[v]) begin
         bit stopped;
         int c;
         mem[0] = vecs[v].bad0 ? 8'h00 : 8'h47;
         LOOP = vecs[v].loop;
         reset_mon();
         mon_en = 1'b1;
         pulse_start(vecs[v].num);
         stopped = 1'b0;
         c = 0;
         while (done_cnt == 0 && c < 3000) begin
            if (vecs[v].stop_at >= 0 && !stopped && valid_cnt >= vecs[v].stop_at) begin
               STOP = 1'b1;
               stopped = 1'b1;
            end
            tick();
            STOP = 1'b0;
            c++;
         end
         LOOP = 1'b0;
         repeat (8) tick();
         chk({vecs[v].name, "_done_cnt"}, done_cnt, 1);
         chk({vecs[v].name, "_valid_cnt"}, valid_cnt, vecs[v].exp_valid);
         chk({vecs[v].name, "_rd_cnt"}, rd_cnt, vecs[v].exp_rd);
         chk({vecs[v].name, "_rd_addr0"}, rd0_cnt, vecs[v].exp_rd0);
         chk({vecs[v].name, "_last_addr"}, last_addr, vecs[v].exp_last);
         chk({vecs[v].name, "_sync_err"}, int'(SYNC_ERR), int'(vecs[v].exp_serr));
         chk({vecs[v].name, "_busy_seen"}, int'(busy_cnt > 0), int'(vecs[v].num > 0));
         chk({vecs[v].name, "_stream"}, mon_bad, 0);
         chk({vecs[v].name, "_idle"}, int'(BUSY), 0);
      end

      // First-byte latency, SYNC_ERR clear on START, DONE aligned with last byte
      mem[0] = 8'h47;
      reset_mon();
      chk("serr_before_start", int'(SYNC_ERR), 1);
      pulse_start(1);
      chk("lat_n_rd", int'(MEM_RD), 1);
      chk("lat_n_addr", int'(MEM_ADDR), 0);
      chk("lat_n_busy", int'(BUSY), 1);
      chk("lat_n_serr_clr", int'(SYNC_ERR), 0);
      tick();
      chk("lat_n1_valid", int'(TS_VALID), 0);
      chk("lat_n1_addr", int'(MEM_ADDR), 1);
      tick();
      chk("lat_n2_valid", int'(TS_VALID), 1);
      chk("lat_n2_sync", int'(TS_SYNC), 1);
      chk("lat_n2_data", int'(TS_DATA), 8'h47);
      tick();
      chk("lat_n3_sync", int'(TS_SYNC), 0);
      chk("lat_n3_data", int'(TS_DATA), 1);
      wait_done("lat");
      chk("done_with_last_valid", int'(TS_VALID), 1);
      chk("done_last_data", int'(TS_DATA), 187);
      chk("done_busy_clr", int'(BUSY), 0);
      tick();
      chk("after_done_valid", int'(TS_VALID), 0);
      chk("after_done_pulse", int'(DONE), 0);
      chk("lat_stream", mon_bad, 0);

      // START and STOP together in IDLE: STOP wins
      reset_mon();
      START = 1'b1; STOP = 1'b1; NUM_PKTS = 2;
      tick();
      START = 1'b0; STOP = 1'b0;
      chk("startstop_busy", int'(BUSY), 0);
      chk("startstop_done", int'(DONE), 0);
      repeat (3) tick();
      chk("startstop_reads", rd_cnt, 0);

      // NUM_PKTS=0: DONE on the very next edge
      pulse_start(0);
      chk("zero_done_next", int'(DONE), 1);
      chk("zero_rd", int'(MEM_RD), 0);
      tick();
      chk("zero_done_pulse", int'(DONE), 0);

      // START while busy is ignored
      reset_mon();
      pulse_start(1);
      for (int c = 0; c < 100 && valid_cnt < 20; c++) tick();
      pulse_start(5);
      wait_done("busy_start");
      repeat (8) tick();
      chk("busy_start_valid", valid_cnt, 188);
      chk("busy_start_rd", rd_cnt, 188);
      chk("busy_start_stream", mon_bad, 0);

      // RESET mid-packet aborts at once; replay then restarts from address 0
      reset_mon();
      pulse_start(2);
      for (int c = 0; c < 300 && valid_cnt < 100; c++) tick();
      chk("rst_reached_byte100", valid_cnt, 100);
      mon_en = 1'b0;
      RESET = 1'b1;
      #1;
      chk("rst_mid_outs_zero", int'({MEM_RD, MEM_ADDR, TS_VALID, TS_SYNC, TS_DATA,
                                     BUSY, DONE, SYNC_ERR} == '0), 1);
      tick();
      RESET = 1'b0;
      repeat (4) tick();
      chk("rst_after_valid", int'(TS_VALID), 0);
      chk("rst_after_rd", int'(MEM_RD), 0);
      pulse_start(1);
      chk("rst_restart_rd", int'(MEM_RD), 1);
      chk("rst_restart_addr", int'(MEM_ADDR), 0);
      wait_done("rst_restart");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
